// File: rtl/datapath_gen.sv
// datapath_gen: parametrised register file + ALU datapath fed from a single
// source-selected Xbus, with a req/ack debug snapshot bank for the monitor.
// Optional feature macro: DATAPATH_GEN_PC_INC_EN (PC auto-increment via pc_inc).
module datapath_gen #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned NGPR   = 3,
    parameter int unsigned SRC_W  = $clog2(NGPR + 5),
    parameter int unsigned DBG_W  = $clog2(NGPR + 7)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [DATA_W-1:0] RD,
    output logic [DATA_W-1:0] MA,
    output logic [DATA_W-1:0] WD,
    input  logic [SRC_W-1:0]  xsrc,
    input  logic [NGPR+6:0]   xdst,
    input  logic [3:0]        aluop,
    input  logic              pc_inc,
    output logic [DATA_W-1:0] I,
    output logic [2:0]        SZCy,
    input  logic              dbg_req,
    output logic              dbg_ack,
    input  logic [DBG_W-1:0]  dbg_addr0,
    input  logic [DBG_W-1:0]  dbg_addr1,
    output logic [DATA_W-1:0] dbg_data0,
    output logic [DATA_W-1:0] dbg_data1
);

    localparam int unsigned AW      = DATA_W + 1;
    localparam int unsigned NDBG    = NGPR + 7;
    // xdst bit positions above the GPRs
    localparam int unsigned XD_MA   = NGPR + 1;
    localparam int unsigned XD_WD   = NGPR + 2;
    localparam int unsigned XD_I    = NGPR + 3;
    localparam int unsigned XD_T    = NGPR + 4;
    localparam int unsigned XD_R    = NGPR + 5;
    localparam int unsigned XD_FLG  = NGPR + 6;
    // xsrc codes above the GPRs
    localparam int unsigned XS_RD   = NGPR + 1;
    localparam int unsigned XS_R    = NGPR + 2;
    localparam int unsigned XS_FLG  = NGPR + 3;
    localparam int unsigned XS_ONES = NGPR + 4;
    // debug address codes above the GPRs
    localparam int unsigned DB_T    = NGPR + 1;
    localparam int unsigned DB_R    = NGPR + 2;
    localparam int unsigned DB_FLG  = NGPR + 3;
    localparam int unsigned DB_X    = NGPR + 4;
    localparam int unsigned DB_MA   = NGPR + 5;
    localparam int unsigned DB_I    = NGPR + 6;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_CAPTURE = 2'd1,
        S_HOLD    = 2'd2
    } dbg_state_e;

    logic [DATA_W-1:0] pc_q, pc_d;
    logic [DATA_W-1:0] gpr_q [NGPR];
    logic [DATA_W-1:0] gpr_d [NGPR];
    logic [DATA_W-1:0] ma_q, ma_d;
    logic [DATA_W-1:0] wd_q, wd_d;
    logic [DATA_W-1:0] i_q, i_d;
    logic [DATA_W-1:0] t_q, t_d;
    logic [DATA_W-1:0] r_q, r_d;
    logic [DATA_W-1:0] flg_q, flg_d;

    logic [DATA_W-1:0] xbus;
    int unsigned       xsel;
    logic [AW-1:0]     sum_w;
    logic [DATA_W-1:0] alu_res;
    logic              alu_cy;
    logic              cy_in;
    logic [DATA_W-1:0] flg_new;

    logic [DATA_W-1:0] live [NDBG];
    logic [DATA_W-1:0] snap_q [NDBG];
    dbg_state_e        state_q;
    logic              dbg_ack_q;

`ifndef DATAPATH_GEN_PC_INC_EN
    logic unused_pc_inc;
    assign unused_pc_inc = pc_inc;
`endif

    assign cy_in = flg_q[1];

    // Xbus source select; codes past all-ones read as zero
    always_comb begin
        xsel = 32'(xsrc);
        xbus = '0;
        if (xsel == 0) begin
            xbus = pc_q;
        end else if (xsel == XS_RD) begin
            xbus = RD;
        end else if (xsel == XS_R) begin
            xbus = r_q;
        end else if (xsel == XS_FLG) begin
            xbus = flg_q;
        end else if (xsel == XS_ONES) begin
            xbus = '1;
        end
        for (int unsigned k = 0; k < NGPR; k++) begin
            if (xsel == k + 1) begin
                xbus = gpr_q[k];
            end
        end
    end

    // ALU: a = Xbus, b = T; carry/borrow taken from the extra sum bit
    always_comb begin
        sum_w   = '0;
        alu_res = '0;
        alu_cy  = 1'b0;
        case (aluop)
            4'd0: sum_w = {1'b0, xbus} + {1'b0, t_q};
            4'd1: sum_w = {1'b0, xbus} + {1'b0, t_q} + AW'(cy_in);
            4'd2: sum_w = {1'b0, xbus} - {1'b0, t_q};
            4'd3: sum_w = {1'b0, xbus} - {1'b0, t_q} - AW'(cy_in);
            4'd4: sum_w = {1'b0, xbus & t_q};
            4'd5: sum_w = {1'b0, xbus | t_q};
            4'd6: sum_w = {1'b0, xbus ^ t_q};
            4'd7: sum_w = {1'b0, ~xbus};
            4'd8: sum_w = {xbus[DATA_W-1], xbus[DATA_W-2:0], 1'b0};
            4'd9: sum_w = {xbus[0], 1'b0, xbus[DATA_W-1:1]};
            4'd10: sum_w = {xbus[DATA_W-1], xbus[DATA_W-2:0], cy_in};
            4'd11: sum_w = {xbus[0], cy_in, xbus[DATA_W-1:1]};
            4'd12: sum_w = {1'b0, xbus} + AW'(1);
            4'd13: sum_w = {1'b0, xbus} - AW'(1);
            4'd14: sum_w = {1'b0, xbus};
            default: sum_w = {1'b0, t_q};
        endcase
        alu_res = sum_w[DATA_W-1:0];
        alu_cy  = sum_w[DATA_W];
        flg_new = '0;
        flg_new[3:1] = {alu_res[DATA_W-1], (alu_res == '0), alu_cy};
    end

    // Next-state for all architectural registers from xdst enables
    always_comb begin
        pc_d  = pc_q;
        gpr_d = gpr_q;
        ma_d  = ma_q;
        wd_d  = wd_q;
        i_d   = i_q;
        t_d   = t_q;
        r_d   = r_q;
        flg_d = flg_q;
        if (xdst[0]) begin
            pc_d = xbus;
        end
`ifdef DATAPATH_GEN_PC_INC_EN
        else if (pc_inc) begin
            pc_d = pc_q + DATA_W'(1);
        end
`endif
        for (int unsigned k = 0; k < NGPR; k++) begin
            if (xdst[k + 1]) begin
                gpr_d[k] = xbus;
            end
        end
        if (xdst[XD_MA])  ma_d  = xbus;
        if (xdst[XD_WD])  wd_d  = xbus;
        if (xdst[XD_I])   i_d   = xbus;
        if (xdst[XD_T])   t_d   = xbus;
        if (xdst[XD_R])   r_d   = alu_res;
        if (xdst[XD_FLG]) flg_d = flg_new;
    end

    // Architectural register bank
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pc_q  <= '0;
            gpr_q <= '{default: '0};
            ma_q  <= '0;
            wd_q  <= '0;
            i_q   <= '0;
            t_q   <= '0;
            r_q   <= '0;
            flg_q <= '0;
        end else begin
            pc_q  <= pc_d;
            gpr_q <= gpr_d;
            ma_q  <= ma_d;
            wd_q  <= wd_d;
            i_q   <= i_d;
            t_q   <= t_d;
            r_q   <= r_d;
            flg_q <= flg_d;
        end
    end

    // Live view of every debug-visible value, indexed by debug address
    always_comb begin
        live[0] = pc_q;
        for (int unsigned k = 0; k < NGPR; k++) begin
            live[k + 1] = gpr_q[k];
        end
        live[DB_T]   = t_q;
        live[DB_R]   = r_q;
        live[DB_FLG] = flg_q;
        live[DB_X]   = xbus;
        live[DB_MA]  = ma_q;
        live[DB_I]   = i_q;
    end

    // Snapshot handshake FSM; bank latches pre-edge live values on IDLE->CAPTURE
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            dbg_ack_q <= 1'b0;
            snap_q    <= '{default: '0};
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (dbg_req) begin
                        state_q <= S_CAPTURE;
                        snap_q  <= live;
                    end
                end
                S_CAPTURE: begin
                    if (dbg_req) begin
                        state_q   <= S_HOLD;
                        dbg_ack_q <= 1'b1;
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                S_HOLD: begin
                    if (!dbg_req) begin
                        state_q   <= S_IDLE;
                        dbg_ack_q <= 1'b0;
                    end
                end
                default: begin
                    state_q   <= S_IDLE;
                    dbg_ack_q <= 1'b0;
                end
            endcase
        end
    end

    // Debug read ports: snapshot while acked, live otherwise, zero out of range
    always_comb begin
        dbg_data0 = '0;
        dbg_data1 = '0;
        if (32'(dbg_addr0) < NDBG) begin
            dbg_data0 = dbg_ack_q ? snap_q[dbg_addr0] : live[dbg_addr0];
        end
        if (32'(dbg_addr1) < NDBG) begin
            dbg_data1 = dbg_ack_q ? snap_q[dbg_addr1] : live[dbg_addr1];
        end
    end

    assign MA      = ma_q;
    assign WD      = wd_q;
    assign I       = i_q;
    assign SZCy    = flg_q[3:1];
    assign dbg_ack = dbg_ack_q;

endmodule

// File: tb/tb_datapath_gen.sv
// Scoreboard bench for datapath_gen: stimulus pushes expected values, a
// negedge monitor pops and compares them against the DUT outputs.
module tb_datapath_gen;

    localparam int unsigned DW = 8;
    localparam int unsigned NG = 3;
    localparam int unsigned SW = $clog2(NG + 5);
    localparam int unsigned BW = $clog2(NG + 7);
    localparam int unsigned WSW = $clog2(8 + 5);
    localparam int unsigned WBW = $clog2(8 + 7);

    localparam int XD_PC = 0, XD_G0 = 1, XD_G1 = 2, XD_MA = 4, XD_WD = 5;
    localparam int XD_I = 6, XD_T = 7, XD_R = 8, XD_FLG = 9;
    localparam int SEL_D0 = 0, SEL_D1 = 1, SEL_ACK = 2, SEL_SZCY = 3;
    localparam int SEL_MA = 4, SEL_WD = 5, SEL_I = 6, SEL_W0 = 7, SEL_W1 = 8;

    typedef struct {
        string       name;
        int          sel;
        logic [31:0] exp;
    } exp_t;

    logic clk = 1'b0;
    logic rst;

    // default-parameter DUT signals
    logic [DW-1:0] rd;
    logic [DW-1:0] ma, wd, ir;
    logic [SW-1:0] xsrc;
    logic [NG+6:0] xdst;
    logic [3:0]    aluop;
    logic          pc_inc;
    logic [2:0]    szcy;
    logic          dbg_req, dbg_ack;
    logic [BW-1:0] dbg_addr0, dbg_addr1;
    logic [DW-1:0] dbg_data0, dbg_data1;

    // wide DUT signals (DATA_W = 16, NGPR = 8)
    logic [15:0]    w_rd, w_ma, w_wd, w_ir;
    logic [WSW-1:0] w_xsrc;
    logic [14:0]    w_xdst;
    logic [2:0]     w_szcy;
    logic           w_ack;
    logic [WBW-1:0] w_addr0, w_addr1;
    logic [15:0]    w_data0, w_data1;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    datapath_gen u_dut (
        .clock(clk), .reset(rst), .RD(rd), .MA(ma), .WD(wd),
        .xsrc(xsrc), .xdst(xdst), .aluop(aluop), .pc_inc(pc_inc),
        .I(ir), .SZCy(szcy), .dbg_req(dbg_req), .dbg_ack(dbg_ack),
        .dbg_addr0(dbg_addr0), .dbg_addr1(dbg_addr1),
        .dbg_data0(dbg_data0), .dbg_data1(dbg_data1)
    );

    datapath_gen #(.DATA_W(16), .NGPR(8)) u_dut16 (
        .clock(clk), .reset(rst), .RD(w_rd), .MA(w_ma), .WD(w_wd),
        .xsrc(w_xsrc), .xdst(w_xdst), .aluop(4'd0), .pc_inc(1'b0),
        .I(w_ir), .SZCy(w_szcy), .dbg_req(1'b0), .dbg_ack(w_ack),
        .dbg_addr0(w_addr0), .dbg_addr1(w_addr1),
        .dbg_data0(w_data0), .dbg_data1(w_data1)
    );

    function automatic logic [31:0] observe(input int sel);
        case (sel)
            SEL_D0:   return 32'(dbg_data0);
            SEL_D1:   return 32'(dbg_data1);
            SEL_ACK:  return 32'(dbg_ack);
            SEL_SZCY: return 32'(szcy);
            SEL_MA:   return 32'(ma);
            SEL_WD:   return 32'(wd);
            SEL_I:    return 32'(ir);
            SEL_W0:   return 32'(w_data0);
            SEL_W1:   return 32'(w_data1);
            default:  return 32'hDEAD_BEEF;
        endcase
    endfunction

    task automatic push(input string n, input int s, input logic [31:0] v);
        exp_t e;
        e.name = n;
        e.sel  = s;
        e.exp  = v;
        exp_q.push_back(e);
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // one ALU operation into R and FLG, then check R (dbg addr 5) and SZCy
    task automatic alu_step(input string tag, input logic [SW-1:0] src,
                            input logic [7:0] rd_v, input logic [3:0] op,
                            input logic [7:0] er, input logic [2:0] ef);
        xsrc  = src;
        rd    = rd_v;
        aluop = op;
        xdst  = '0;
        xdst[XD_R]   = 1'b1;
        xdst[XD_FLG] = 1'b1;
        cyc(1);
        xdst      = '0;
        dbg_addr1 = BW'(5);
        push({tag, "_R"}, SEL_D1, 32'(er));
        push({tag, "_SZCy"}, SEL_SZCY, 32'(ef));
    endtask

    // monitor: compare every pending expectation on the falling edge
    initial begin
        exp_t  e;
        logic [31:0] got;
        forever begin
            @(negedge clk);
            while (exp_q.size() > 0) begin
                e   = exp_q.pop_front();
                got = observe(e.sel);
                checks++;
                if (got !== e.exp) begin
                    errors++;
                    $display("FAIL %s: got %0h expected %0h", e.name, got, e.exp);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        rd = '0; xsrc = '0; xdst = '0; aluop = '0; pc_inc = 1'b0;
        dbg_req = 1'b0; dbg_addr0 = '0; dbg_addr1 = '0;
        w_rd = '0; w_xsrc = '0; w_xdst = '0; w_addr0 = '0; w_addr1 = '0;
        cyc(2);
        rst = 1'b0;
        dbg_addr1 = BW'(5);
        push("rst_ack", SEL_ACK, 32'h0);
        push("rst_pc", SEL_D0, 32'h0);
        push("rst_r", SEL_D1, 32'h0);
        push("rst_szcy", SEL_SZCY, 32'h0);
        push("rst_ma", SEL_MA, 32'h0);
        cyc(1);

        // all-ones into GPR0 only
        xsrc = SW'(7);
        xdst = '0; xdst[XD_G0] = 1'b1;
        cyc(1);
        xdst = '0;
        dbg_addr0 = BW'(1);
        dbg_addr1 = BW'(0);
        push("gpr0_ones", SEL_D0, 32'hFF);
        push("pc_untouched", SEL_D1, 32'h00);
        cyc(1);

        // T = 01
        xsrc = SW'(4); rd = 8'h01;
        xdst = '0; xdst[XD_T] = 1'b1;
        cyc(1);
        xdst = '0;

        alu_step("add",  SW'(1), 8'h00, 4'd0,  8'h00, 3'b011);
        dbg_addr0 = BW'(6);
        push("flg_reg", SEL_D0, 32'h06);
        alu_step("adc",  SW'(1), 8'h00, 4'd1,  8'h01, 3'b001);
        alu_step("sub",  SW'(4), 8'h00, 4'd2,  8'hFF, 3'b101);
        alu_step("rol",  SW'(4), 8'h80, 4'd10, 8'h01, 3'b001);
        alu_step("sbb",  SW'(4), 8'h05, 4'd3,  8'h03, 3'b000);
        alu_step("and",  SW'(4), 8'hF0, 4'd4,  8'h00, 3'b010);
        alu_step("xor",  SW'(4), 8'h5A, 4'd6,  8'h5B, 3'b000);
        alu_step("shr",  SW'(4), 8'h03, 4'd9,  8'h01, 3'b001);
        alu_step("ror",  SW'(4), 8'h01, 4'd11, 8'h80, 3'b101);
        alu_step("inc",  SW'(4), 8'hFF, 4'd12, 8'h00, 3'b011);
        alu_step("dec",  SW'(4), 8'h00, 4'd13, 8'hFF, 3'b101);
        alu_step("shl",  SW'(4), 8'h81, 4'd8,  8'h02, 3'b001);
        alu_step("not",  SW'(4), 8'h0F, 4'd7,  8'hF0, 3'b100);
        alu_step("passb", SW'(4), 8'h33, 4'd15, 8'h01, 3'b000);
        alu_step("passa", SW'(4), 8'hA5, 4'd14, 8'hA5, 3'b100);
        alu_step("or",   SW'(4), 8'h30, 4'd5,  8'h31, 3'b000);

        // one Xbus value into MA, WD and I together
        xsrc = SW'(4); rd = 8'h3C;
        xdst = '0; xdst[XD_MA] = 1'b1; xdst[XD_WD] = 1'b1; xdst[XD_I] = 1'b1;
        cyc(1);
        xdst = '0;
        push("multi_ma", SEL_MA, 32'h3C);
        push("multi_wd", SEL_WD, 32'h3C);
        push("multi_i", SEL_I, 32'h3C);

        // snapshot: GPR1 = 55, request, overwrite with AA while capturing
        rd = 8'h55;
        xdst = '0; xdst[XD_G1] = 1'b1;
        cyc(1);
        xdst = '0;
        dbg_addr0 = BW'(2);
        dbg_addr1 = BW'(7);
        dbg_req = 1'b1;
        push("pre_req_live", SEL_D0, 32'h55);
        cyc(1);
        push("ack_after_1", SEL_ACK, 32'h0);
        rd = 8'hAA;
        xdst = '0; xdst[XD_G1] = 1'b1;
        cyc(1);
        xdst = '0;
        push("ack_after_2", SEL_ACK, 32'h1);
        push("snap_gpr1", SEL_D0, 32'h55);
        push("snap_xbus", SEL_D1, 32'h55);
        cyc(1);
        dbg_req = 1'b0;
        push("hold_until_edge", SEL_ACK, 32'h1);
        push("hold_gpr1", SEL_D0, 32'h55);
        cyc(1);
        push("ack_drop", SEL_ACK, 32'h0);
        push("live_gpr1", SEL_D0, 32'hAA);
        push("live_xbus", SEL_D1, 32'hAA);
        cyc(1);

        // request withdrawn during CAPTURE: ack never rises
        dbg_req = 1'b1;
        cyc(1);
        dbg_req = 1'b0;
        push("abort_a", SEL_ACK, 32'h0);
        cyc(1);
        push("abort_b", SEL_ACK, 32'h0);
        cyc(1);
        push("abort_c", SEL_ACK, 32'h0);

        // reset while in HOLD clears ack and every register at once
        xsrc = SW'(0);
        dbg_addr1 = BW'(5);
        dbg_req = 1'b1;
        cyc(2);
        push("hold_again", SEL_ACK, 32'h1);
        push("snap_r", SEL_D1, 32'h31);
        cyc(1);
        rst = 1'b1;
        push("rst_hold_ack", SEL_ACK, 32'h0);
        push("rst_hold_gpr1", SEL_D0, 32'h0);
        push("rst_hold_r", SEL_D1, 32'h0);
        cyc(1);
        dbg_req = 1'b0;
        cyc(1);
        rst = 1'b0;
        cyc(1);

        // PC increment request, then xdst[0] priority over pc_inc
        xsrc = SW'(4); rd = 8'hFF;
        xdst = '0; xdst[XD_PC] = 1'b1;
        cyc(1);
        xdst = '0;
        pc_inc = 1'b1;
        cyc(1);
        pc_inc = 1'b0;
        dbg_addr0 = BW'(0);
`ifdef DATAPATH_GEN_PC_INC_EN
        push("pc_inc_wrap", SEL_D0, 32'h00);
`else
        push("pc_inc_ignored", SEL_D0, 32'hFF);
`endif
        rd = 8'h40;
        pc_inc = 1'b1;
        xdst = '0; xdst[XD_PC] = 1'b1;
        cyc(1);
        xdst = '0;
        pc_inc = 1'b0;
        push("pc_write_priority", SEL_D0, 32'h40);
        cyc(1);

        // wide instance: GPR7 loads from RD and reads back via Xbus and debug
        w_rd = 16'hBEEF;
        w_xsrc = WSW'(9);
        w_xdst = '0; w_xdst[8] = 1'b1;
        cyc(1);
        w_xdst = '0;
        w_xsrc = WSW'(8);
        w_addr0 = WBW'(8);
        w_addr1 = WBW'(12);
        push("w16_gpr7", SEL_W0, 32'hBEEF);
        push("w16_xbus", SEL_W1, 32'hBEEF);
        cyc(1);

        @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/datapath_gen.md
Name: datapath_gen

Overview:
- Parametrised successor of the cdecv 8-bit datapath: configurable data width and general-purpose register (GPR) count, with the ALU built in.
- Registers: PC, GPR file, MA, WD, I, T, R, FLG, all fed from a single source-selected Xbus.
- Adds a debug snapshot with a req/ack handshake, so the monitor can read a coherent register set while the CPU keeps running.
- Sits between the control unit and the memory, as the old datapath did.

Parameters:
- DATA_W, 8, datapath width; must be >= 4.
- NGPR, 3, number of GPRs (GPR0 is the old A); range 1..8.
- SRC_W, $clog2(NGPR+5), width of the xsrc select.
- DBG_W, $clog2(NGPR+7), width of the debug address.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- RD  in  DATA_W  memory read data.
- MA  out  DATA_W  memory address register.
- WD  out  DATA_W  memory write-data register.
- xsrc  in  SRC_W  Xbus source: 0 PC; 1..NGPR GPR0..; NGPR+1 RD; NGPR+2 R; NGPR+3 FLG; NGPR+4 all-ones; higher values give 0.
- xdst  in  NGPR+7  write enables: bit0 PC; bits 1..NGPR GPRs; then MA, WD, I, T, R, FLG (MSB).
- aluop  in  4  ALU operation.
- pc_inc  in  1  PC increment request (optional feature).
- I  out  DATA_W  instruction register.
- SZCy  out  3  FLG[3:1].
- dbg_req  in  1  snapshot request (level).
- dbg_ack  out  1  snapshot valid/held.
- dbg_addr0, dbg_addr1  in  DBG_W  debug select: 0 PC; 1..NGPR GPR; NGPR+1 T; NGPR+2 R; NGPR+3 FLG; NGPR+4 Xbus; NGPR+5 MA; NGPR+6 I.
- dbg_data0, dbg_data1  out  DATA_W  debug read data.

Behaviour:
- Reset (asynchronous): every register, including the snapshot bank, clears to 0; dbg_ack = 0; FSM goes to IDLE.
- Register writes: on the rising clock edge, each register whose xdst bit is set loads Xbus.
  - R loads the ALU result; FLG loads {0…, S, Z, Cy, 0}.
  - Several enables may be set in one cycle; all the selected registers load the same value.
- ALU: a = Xbus, b = T, all DATA_W-bit modulo arithmetic.
  - 0 ADD, 1 ADC (+Cy), 2 SUB, 3 SBB (−Cy); for SUB/SBB, Cy = borrow.
  - 4 AND, 5 OR, 6 XOR, 7 NOT a; logic ops give Cy = 0.
  - 8 SHL (Cy = a msb), 9 SHR logical (Cy = a lsb).
  - 10 ROL through Cy, 11 ROR through Cy.
  - 12 INC a, 13 DEC a; Cy = carry/borrow out.
  - 14 pass a, 15 pass b; Cy = 0.
  - S = result msb; Z = (result == 0).
  - ALU Cy_in is the registered FLG[1].
- Snapshot FSM, states IDLE, CAPTURE, HOLD:
  - IDLE→CAPTURE when dbg_req is sampled high. At that edge the snapshot bank latches the pre-edge values of all debug-visible registers plus the current Xbus.
  - CAPTURE→HOLD on the next edge; dbg_ack = 1 in HOLD, i.e. 2 cycles after req.
  - HOLD→IDLE when dbg_req is sampled low; dbg_ack falls at that edge.
  - dbg_req dropping during CAPTURE: go to IDLE; dbg_ack is never asserted.
- Debug reads: combinational. When dbg_ack = 1, dbg_data* read the snapshot bank; otherwise they read live values. Out-of-range dbg_addr returns 0.
- The snapshot never stalls the datapath; live register writes continue during HOLD.
- Reset asserted mid-handshake: FSM returns to IDLE and dbg_ack drops immediately (asynchronous).

Optional Feature:
- Macro DATAPATH_GEN_PC_INC_EN.
- Defined:
  - pc_inc = 1 with xdst[0] = 0: PC <= PC + 1, wrapping from all-ones to 0.
  - xdst[0] = 1 takes priority over pc_inc.
- Undefined: pc_inc is ignored and PC changes only through xdst[0].

Test Plan:
- Reset, then set xsrc = NGPR+4 and pulse xdst bit1 for one cycle: PC = 0 and GPR0 = 8'hFF; dbg_addr0 = 1 reads FF.
- T = 8'h01, GPR0 = 8'hFF, xsrc = 1, aluop = 0, R and FLG enabled: R = 00 and SZCy = 3'b011. Then aluop = 1 with the same operands: R = 01.
- T = 8'h01, Xbus = 8'h00, aluop = 2: R = FF and SZCy = 3'b101. Then aluop = 10 with Xbus = 80 and Cy = 1: R = 01, Cy = 1.
- Load GPR1 = 55, raise dbg_req, then write GPR1 = AA on the following cycle: dbg_ack rises 2 cycles after req and dbg_data (addr 2) reads 55. Drop req: dbg_ack = 0 and the read becomes AA.
- Assert reset while in HOLD: dbg_ack = 0 immediately and all dbg reads return 0.
- With DATAPATH_GEN_PC_INC_EN, PC = FF, pc_inc = 1: PC = 00. With pc_inc and xdst[0] both set and Xbus = 40: PC = 40. Rerun with DATA_W = 16, NGPR = 8: GPR7 (xsrc 8) loads and reads back 16'hBEEF.
